// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes and debounce FSM states.
// Reused by the row-scan decoder, entry buffer and seven-segment driver.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic [KEY_W-1:0] KEY_A     = 4'hA;
  localparam logic [KEY_W-1:0] KEY_B     = 4'hB;
  localparam logic [KEY_W-1:0] KEY_C     = 4'hC;
  localparam logic [KEY_W-1:0] KEY_D     = 4'hD;
  localparam logic [KEY_W-1:0] KEY_STAR  = 4'hE;
  localparam logic [KEY_W-1:0] KEY_POUND = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_HELD,
    ST_DB_RELEASE
  } db_state_e;

  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Column synchronizer and press/release debounce FSM.
// Emits one key_event per accepted press and latches the decoder key code.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] column,
  input  logic [KEY_W-1:0] key,
  output logic             key_event,
  output logic [KEY_W-1:0] key_code
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The state change happens on the edge where the count would reach DEBOUNCE_CYCLES-1.
  localparam int unsigned LAST  = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;

  logic [KEY_W-1:0] col_s1;
  logic [KEY_W-1:0] col_s2;
  logic             raw_pressed;
  logic             at_last;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  assign raw_pressed = (col_s2 != 4'hF);
  assign at_last     = (cnt == CNT_W'(LAST));

  // Two-flop synchronizer; reset value reads as "no column pulled low".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= column;
      col_s2 <= col_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_event <= 1'b0;
      key_code  <= '0;
    end else begin
      key_event <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (raw_pressed) begin
            state <= ST_DB_PRESS;
            cnt   <= '0;
          end
        end
        ST_DB_PRESS: begin
          if (!raw_pressed) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (at_last) begin
            state     <= ST_HELD;
            cnt       <= '0;
            key_event <= 1'b1;
            key_code  <= key;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!raw_pressed) begin
            state <= ST_DB_RELEASE;
            cnt   <= '0;
          end
        end
        ST_DB_RELEASE: begin
          if (raw_pressed) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (at_last) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounced key events feed a BCD entry buffer with
// backspace, clear and enter/commit handling.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [KEY_W-1:0]        column,
  input  logic [KEY_W-1:0]        key,
  output logic                    key_event,
  output logic [KEY_W-1:0]        key_code,
  output logic [4*NUM_DIGITS-1:0] display_bcd,
  output logic [3:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_valid,
  output logic                    overflow
);

  localparam int unsigned BUF_W = 4 * NUM_DIGITS;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .column   (column),
    .key      (key),
    .key_event(key_event),
    .key_code (key_code)
  );

  // Buffer acts on the key_event cycle; digit 0 (newest) lives in [3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_bcd <= '0;
      digit_count <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      overflow    <= 1'b0;
      if (key_event) begin
        if (is_digit(key_code)) begin
          if (digit_count < 4'(NUM_DIGITS)) begin
            display_bcd <= (display_bcd << 4) | BUF_W'(key_code);
            digit_count <= digit_count + 4'd1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          case (key_code)
            KEY_D: begin
              if (digit_count != 4'd0) begin
                display_bcd <= display_bcd >> 4;
                digit_count <= digit_count - 4'd1;
              end
            end
            KEY_STAR: begin
              display_bcd <= '0;
              digit_count <= '0;
            end
            KEY_POUND: begin
              value_out   <= display_bcd;
              value_valid <= 1'b1;
              display_bcd <= '0;
              digit_count <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized bench for keypad_entry against a run-length debounce model
// and a digit-queue entry buffer model; directed scenarios plus random presses.
module tb_keypad_entry;

  localparam int N  = 4;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  column;
  logic [3:0]  key;
  logic        key_event;
  logic [3:0]  key_code;
  logic [15:0] display_bcd;
  logic [3:0]  digit_count;
  logic [15:0] value_out;
  logic        value_valid;
  logic        overflow;

  always #5 clk = ~clk;

  keypad_entry #(
    .NUM_DIGITS     (N),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .column     (column),
    .key        (key),
    .key_event  (key_event),
    .key_code   (key_code),
    .display_bcd(display_bcd),
    .digit_count(digit_count),
    .value_out  (value_out),
    .value_valid(value_valid),
    .overflow   (overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state: a level is accepted after DB consecutive samples of it,
  // seen through a two-cycle synchronizer delay.
  bit          hist[$];
  bit          accepted;
  int          run;
  bit          exp_ev;
  logic [3:0]  exp_code;
  int          q[$];        // entered digits, oldest first
  logic [15:0] exp_value;
  bit          exp_vv;
  bit          exp_ovf;
  int          ev_seen, ovf_seen, vv_seen;

  function automatic logic [15:0] model_disp();
    logic [15:0] v;
    v = '0;
    foreach (q[i]) v = 16'(v * 16 + 16'(q[i]));
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    accepted  = 1'b0;
    run       = 0;
    q.delete();
    exp_ev    = 1'b0;
    exp_code  = '0;
    exp_value = '0;
    exp_vv    = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic apply(input logic [3:0] c);
    if (c <= 4'd9) begin
      if (q.size() < N) q.push_back(int'(c));
      else exp_ovf = 1'b1;
    end else if (c == 4'hD) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (c == 4'hE) begin
      q.delete();
    end else if (c == 4'hF) begin
      exp_value = model_disp();
      exp_vv    = 1'b1;
      q.delete();
    end
  endtask

  task automatic model_edge(input bit p, input logic [3:0] k);
    bit eff;
    bit ev_now;
    ev_now = 1'b0;
    hist.push_back(p);
    if (hist.size() > 3) void'(hist.pop_front());
    eff = (hist.size() == 3) ? hist[0] : 1'b0;
    exp_vv  = 1'b0;
    exp_ovf = 1'b0;
    if (exp_ev) apply(exp_code);
    if (eff != accepted) begin
      run++;
      if (run == DB) begin
        accepted = eff;
        run      = 0;
        if (eff) begin
          ev_now   = 1'b1;
          exp_code = k;
        end
      end
    end else begin
      run = 0;
    end
    exp_ev = ev_now;
  endtask

  task automatic step(input bit p, input logic [3:0] k);
    column = p ? 4'($urandom_range(0, 14)) : 4'hF;
    key    = k;
    @(posedge clk);
    #1;
    model_edge(p, k);
    chk("key_event",   32'(key_event),   32'(exp_ev));
    chk("key_code",    32'(key_code),    32'(exp_code));
    chk("display_bcd", 32'(display_bcd), 32'(model_disp()));
    chk("digit_count", 32'(digit_count), 32'(q.size()));
    chk("value_out",   32'(value_out),   32'(exp_value));
    chk("value_valid", 32'(value_valid), 32'(exp_vv));
    chk("overflow",    32'(overflow),    32'(exp_ovf));
    if (key_event)   ev_seen++;
    if (overflow)    ovf_seen++;
    if (value_valid) vv_seen++;
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    repeat (hold) step(1'b1, k);
    repeat (gap) step(1'b0, 4'($urandom));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_event"}, 32'(key_event),   32'd0);
    chk({tag, "_code"},  32'(key_code),    32'd0);
    chk({tag, "_disp"},  32'(display_bcd), 32'd0);
    chk({tag, "_count"}, 32'(digit_count), 32'd0);
    chk({tag, "_value"}, 32'(value_out),   32'd0);
    chk({tag, "_vv"},    32'(value_valid), 32'd0);
    chk({tag, "_ovf"},   32'(overflow),    32'd0);
  endtask

  // One-cycle async reset pulse, called just after a sampling point.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ev_at;
    rst_n  = 1'b0;
    column = 4'hF;
    key    = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    ev_seen = 0;
    press(4'd1, 10, 10);
    press(4'd2, 10, 10);
    press(4'd3, 10, 10);
    chk("p123_events", 32'(ev_seen), 32'd3);
    chk("p123_disp", 32'(display_bcd), 32'h0123);
    chk("p123_count", 32'(digit_count), 32'd3);

    ev_seen = 0;
    step(1'b1, 4'd5);
    step(1'b1, 4'd5);
    repeat (10) step(1'b0, 4'd5);
    chk("glitch_events", 32'(ev_seen), 32'd0);
    chk("glitch_disp", 32'(display_bcd), 32'h0123);

    press(4'hE, 10, 10);
    ovf_seen = 0;
    press(4'd1, 10, 10);
    press(4'd2, 10, 10);
    press(4'd3, 10, 10);
    press(4'd4, 10, 10);
    press(4'd5, 10, 10);
    chk("ovf_pulses", 32'(ovf_seen), 32'd1);
    chk("ovf_disp", 32'(display_bcd), 32'h1234);
    chk("ovf_count", 32'(digit_count), 32'd4);

    press(4'hE, 10, 10);
    press(4'd7, 10, 10);
    press(4'd8, 10, 10);
    press(4'hD, 10, 10);
    chk("bs1_disp", 32'(display_bcd), 32'h0007);
    chk("bs1_count", 32'(digit_count), 32'd1);
    press(4'hD, 10, 10);
    chk("bs2_disp", 32'(display_bcd), 32'h0000);
    chk("bs2_count", 32'(digit_count), 32'd0);
    press(4'hD, 10, 10);
    chk("bs3_disp", 32'(display_bcd), 32'h0000);
    chk("bs3_count", 32'(digit_count), 32'd0);

    vv_seen = 0;
    press(4'd4, 10, 10);
    press(4'd2, 10, 10);
    press(4'hF, 10, 10);
    chk("enter_value", 32'(value_out), 32'h0042);
    chk("enter_vv_pulses", 32'(vv_seen), 32'd1);
    chk("enter_disp", 32'(display_bcd), 32'h0000);
    chk("enter_count", 32'(digit_count), 32'd0);

    ev_seen = 0;
    repeat (20) step(1'b1, 4'd9);
    chk("hold_pre_events", 32'(ev_seen), 32'd1);
    reset_pulse();
    ev_seen = 0;
    ev_at   = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 4'd9);
      if (key_event && ev_at < 0) ev_at = i;
    end
    chk("hold_post_events", 32'(ev_seen), 32'd1);
    chk("hold_event_at", 32'(ev_at), 32'd6);
    chk("hold_code", 32'(key_code), 32'd9);
    repeat (10) step(1'b0, 4'd0);

    for (int i = 0; i < 300; i++) begin
      press(4'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
      if ($urandom_range(0, 39) == 0) reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Sits directly downstream of the 4x4 keypad row-scan decoder.
- Consumes the decoder's 4-bit key code plus the raw column lines and debounces press/release.
- Emits one event per physical press and assembles a multi-digit BCD entry buffer.
- The buffer drives the seven-segment display path and produces a committed value on the # key.

Parameters:
- NUM_DIGITS, 4, number of BCD digits held in the entry buffer (1..8).
- DEBOUNCE_CYCLES, 240000, clk cycles a level must be stable before it is accepted (20 ms at 12 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, do not override).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- column  input  4  raw keypad column lines, active-low, same wires the decoder samples
- key  input  4  key code from decoder: 0-9 digits, A/B/C = 1010/1011/1100, D = 1101, * = 1110, # = 1111
- key_event  output  1  one-cycle pulse per debounced press
- key_code  output  4  code latched at the last key_event
- display_bcd  output  4*NUM_DIGITS  entry buffer; digit 0 (newest) in [3:0], unused digits 0
- digit_count  output  4  number of valid digits, 0..NUM_DIGITS
- value_out  output  4*NUM_DIGITS  last committed entry
- value_valid  output  1  one-cycle pulse when value_out updates
- overflow  output  1  one-cycle pulse when a digit is rejected because the buffer is full

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM to IDLE, counter 0, sync flops to 4'hF.
- Input sync: column passes through a 2-flop synchronizer. raw_pressed = (synced column != 4'hF).
- The decoder holds its row while a key is down, so raw_pressed stays high for the whole hold apart from bounce.
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE. The counter clears on every state change.
  - IDLE: raw_pressed -> DB_PRESS.
  - DB_PRESS: raw_pressed low -> IDLE with no event. Counter reaches DEBOUNCE_CYCLES-1 -> HELD, key_event=1 that cycle, key_code<=key.
  - HELD: raw_pressed low -> DB_RELEASE. No repeat events while held.
  - DB_RELEASE: raw_pressed high -> HELD with no new event. Counter reaches DEBOUNCE_CYCLES-1 -> IDLE.
- Event latency: key_event asserts DEBOUNCE_CYCLES+2 cycles after column goes stably low (includes 2 sync cycles).
- Buffer action is taken on the key_event cycle. display_bcd, digit_count and value_out are visible the following cycle. value_valid and overflow pulse the following cycle.
- Digit 0-9:
  - If digit_count < NUM_DIGITS: shift buffer left 4 bits, insert code at [3:0], increment count.
  - Else: buffer unchanged, overflow=1.
- D (backspace): if count > 0, shift right 4 bits, zero-fill the top digit, decrement count. At count 0: no-op.
- * (clear): buffer 0, count 0.
- # (enter): value_out<=display_bcd, value_valid=1, then buffer 0, count 0. Enter on an empty buffer commits 0 and still pulses.
- A/B/C: ignored. key_event and key_code still update.
- Reset mid-press: the FSM restarts in IDLE. A key still held after reset produces exactly one event after a full debounce.
- Bounce shorter than DEBOUNCE_CYCLES in any DB state produces no event.

Decomposition:
- Shared package keypad_pkg:
  - key code localparams KEY_A, KEY_B, KEY_C, KEY_D, KEY_STAR(4'hE), KEY_POUND(4'hF).
  - FSM state encoding.
  - These are reused by the decoder and the seven-segment driver.
- One sub-module, key_debounce: synchronizer plus FSM plus counter; outputs key_event and key_code.
- keypad_entry instantiates key_debounce and owns the buffer logic.

Test Plan (DEBOUNCE_CYCLES=4, NUM_DIGITS=4):
- Press 1, 2, 3, each held 10 cycles with 10 cycles released between presses. Required: three key_event pulses, display_bcd=16'h0123, digit_count=3.
- Column toggles low for 2 cycles then high, key=5. Required: no key_event; buffer unchanged.
- Enter 1,2,3,4, then 5. Required: 5 rejected, overflow pulses once, display_bcd=16'h1234, count stays 4.
- Press 7, 8, then D. Required: display_bcd=16'h0007, count=1. A second D gives 0/0, and a third D is a no-op.
- Enter 4,2 then #. Required: value_out=16'h0042, value_valid high exactly 1 cycle, then display_bcd=0 and count=0.
- Hold key 9 for 50 cycles, and assert rst_n low for 1 cycle in the middle. Required: all outputs 0 immediately, then exactly one key_event for 9 after 6 more cycles of the hold.
